sine_lut_reader: RTL and testbench

Pipelined phase-to-amplitude converter that consumes the 16-bit phase address produced by the phase accumulator and returns a signed 16-bit sine sample. It is the reading end of the accumulator's address interface and sits between the accumulator and the output DAC/mixer path. It uses a 256-entry quarter-wave ROM with quadrant mirroring and negation, a 3-cycle valid pipeline, and a zero-crossing strobe.

---
 rtl/sine_lut_reader.sv | 94 +++++++++
 tb/tb_sine_lut_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_reader.sv
// Phase-to-amplitude: 16-bit phase -> signed 16-bit sine via quarter-wave ROM with mirroring/negation.
// Three register stages (i_valid -> o_valid), one sample per clock, no stalls and no backpressure.
module sine_lut_reader (
    input  logic        i_clk5MHz,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_valid,
    output logic [15:0] o_sample,
    output logic        o_valid,
    output logic        o_zc
);

    // pi scaled by 2^60; all table math is done in 128-bit fixed point so rounding is exact.
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

    function automatic logic [14:0] quarter_sine(input int k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        x    = (128'(PI_Q60) * 128'(2 * k + 1)) >> 10;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if ((n % 2) == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        return 15'((sum * 128'd32767 + (128'd1 << 59)) >> 60);
    endfunction

    logic [14:0] w_rom [256];

    for (genvar k = 0; k < 256; k++) begin : g_rom
        localparam logic [14:0] ROM_VAL = quarter_sine(k);
        assign w_rom[k] = ROM_VAL;
    end

    logic        r_s1_vld;
    logic        r_s1_neg;
    logic [7:0]  r_s1_idx;
    logic        r_s2_vld;
    logic        r_s2_neg;
    logic [14:0] r_s2_rom;
    logic        r_prev_neg;
    logic [15:0] w_mag;
    logic        w_unused;

    // Phase LSBs are truncated, not interpolated.
    assign w_unused = ^i_addr[5:0];
    assign w_mag    = {1'b0, r_s2_rom};

    always_ff @(posedge i_clk5MHz) begin
        if (i_rst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= i_valid;
        end
        r_s1_neg <= i_addr[15];
        r_s1_idx <= i_addr[14] ? ~i_addr[13:6] : i_addr[13:6];
    end

    always_ff @(posedge i_clk5MHz) begin
        if (i_rst) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
        end
        r_s2_neg <= r_s1_neg;
        r_s2_rom <= w_rom[r_s1_idx];
    end

    // Every table entry is >= 101, so the negate flag is exactly the sample's sign.
    always_ff @(posedge i_clk5MHz) begin
        if (i_rst) begin
            o_sample   <= 16'd0;
            o_valid    <= 1'b0;
            o_zc       <= 1'b0;
            r_prev_neg <= 1'b0;
        end else begin
            o_valid <= r_s2_vld;
            o_zc    <= 1'b0;
            if (r_s2_vld) begin
                o_sample   <= r_s2_neg ? -w_mag : w_mag;
                o_zc       <= r_prev_neg & ~r_s2_neg;
                r_prev_neg <= r_s2_neg;
            end
        end
    end

endmodule

// File: tb/tb_sine_lut_reader.sv
// Scoreboard bench for sine_lut_reader: stimulus pushes expected samples, a monitor pops on o_valid.
module tb_sine_lut_reader;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_addr = 16'd0;
    logic        i_valid = 1'b0;
    logic [15:0] o_sample;
    logic        o_valid;
    logic        o_zc;

    typedef struct packed {
        logic [15:0] s;
        logic        zc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_zc  = 0;
    bit   model_neg = 1'b0;
    bit   mon_en = 1'b0;

    sine_lut_reader dut (
        .i_clk5MHz(clk),
        .i_rst    (i_rst),
        .i_addr   (i_addr),
        .i_valid  (i_valid),
        .o_sample (o_sample),
        .o_valid  (o_valid),
        .o_zc     (o_zc)
    );

    always #100 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h), required %0d (0x%h) at %0t", name,
                     $signed(act), act, $signed(req), req, $time);
        end
    endtask

    function automatic int model(input logic [15:0] a);
        int  k;
        int  t;
        real r;
        k = int'(a[13:6]);
        if (a[14]) k = 255 - k;
        r = $sin(3.14159265358979323846 * real'(2 * k + 1) / 1024.0);
        t = $rtoi(32767.0 * r + 0.5);
        return a[15] ? -t : t;
    endfunction

    // Monitor: compare every presented output against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (o_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got sample %0d, required no output at %0t",
                             $signed(o_sample), $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("sample", o_sample, mon_e.s);
                    check("zc", {15'd0, o_zc}, {15'd0, mon_e.zc});
                    check("never_8000", {15'd0, o_sample == 16'h8000}, 16'd0);
                end
                if (o_zc === 1'b1) n_zc++;
            end else begin
                check("zc_idle", {15'd0, o_zc}, 16'd0);
            end
        end
    end

    task automatic drive(input logic [15:0] a);
        @(negedge clk);
        i_addr  = a;
        i_valid = 1'b1;
    endtask

    task automatic send(input logic [15:0] a, input int exp_v);
        exp_t e;
        drive(a);
        e.s  = 16'(exp_v);
        e.zc = model_neg && (exp_v >= 0);
        model_neg = (exp_v < 0);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && sb.size() > 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset(input logic valid_during);
        @(negedge clk);
        i_rst   = 1'b1;
        i_valid = valid_during;
        i_addr  = 16'h0000;
        @(negedge clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        model_neg = 1'b0;
        mon_en  = 1'b1;
        check("rst_sample", o_sample, 16'd0);
        check("rst_valid", {15'd0, o_valid}, 16'd0);
        check("rst_zc", {15'd0, o_zc}, 16'd0);
    endtask

    initial begin
        // First sample after reset: +101, no zero crossing, then held.
        do_reset(1'b0);
        send(16'h0000, 101);
        idle(1);
        drain();
        idle(2);
        check("hold_sample", o_sample, 16'd101);
        check("hold_valid", {15'd0, o_valid}, 16'd0);

        // Quadrant boundaries and ignored low bits, back to back.
        send(16'h3FC0, 32767);
        send(16'h4000, 32767);
        send(16'h8000, -101);
        send(16'hC000, -32767);
        send(16'hFFC0, -101);
        send(16'h003F, 101);
        idle(1);
        drain();

        // Two full laps free-running; exactly one crossing, at the second-lap wrap.
        do_reset(1'b0);
        n_zc = 0;
        for (int j = 0; j < 2048; j++) send(16'(j * 64), model(16'(j * 64)));
        idle(1);
        drain();
        check("stream_zc_count", 16'(n_zc), 16'd1);

        // Crossing detection spans an input gap.
        send(16'hC000, -32767);
        idle(5);
        send(16'h0000, 101);
        idle(1);
        drain();

        // Reset with samples in flight and i_valid high during reset: nothing emerges.
        drive(16'h4000);
        drive(16'h8000);
        do_reset(1'b1);
        idle(5);
        check("midrst_sample", o_sample, 16'd0);
        check("midrst_zc", {15'd0, o_zc}, 16'd0);
        send(16'h8000, -101);
        send(16'h0000, 101);
        idle(1);
        drain();

        // Full index/quadrant sweep with random low bits and random gaps.
        for (int j = 0; j < 1024; j++) begin
            logic [15:0] a;
            a = 16'(j * 64) | 16'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) idle(1);
            send(a, model(a));
        end
        idle(1);
        drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(200 * 20000);
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
